// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with a valid/ready
// handshake on both sides. Stage 1 registers the operands and opcode; stage 2
// computes the result and registers it together with zero/parity/illegal flags.
// There is no skid buffer, so in_ready is combinational from out_ready.
//
// Optional build macro: LOGIC_UNIT_PIPE_OPCNT_EN adds op_count (consumed beats,
// wrapping) and illegal_count (consumed illegal beats, saturating).
module logic_unit_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   logic_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  parity,
  output logic                  illegal_op
`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
  ,
  output logic [15:0]           op_count,
  output logic [7:0]            illegal_count
`endif
);

  localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_NOT_A  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_NAND   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_NOR    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XNOR   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_ANDN   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_PASS_A = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_PASS_B = OP_WIDTH'(9);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [OP_WIDTH-1:0]   s1_op;
  logic                  s2_valid;
  logic                  s1_adv;
  logic                  s2_adv;
  logic [DATA_WIDTH-1:0] calc_result;
  logic                  calc_illegal;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage-2 combinational datapath on the stage-1 contents.
  always_comb begin
    calc_result  = '0;
    calc_illegal = 1'b0;
    case (s1_op)
      OP_AND:    calc_result = s1_a & s1_b;
      OP_OR:     calc_result = s1_a | s1_b;
      OP_XOR:    calc_result = s1_a ^ s1_b;
      OP_NOT_A:  calc_result = ~s1_a;
      OP_NAND:   calc_result = ~(s1_a & s1_b);
      OP_NOR:    calc_result = ~(s1_a | s1_b);
      OP_XNOR:   calc_result = ~(s1_a ^ s1_b);
      OP_ANDN:   calc_result = s1_a & ~s1_b;
      OP_PASS_A: calc_result = s1_a;
      OP_PASS_B: calc_result = s1_b;
      default:   calc_illegal = 1'b1;
    endcase
  end

  // Stage 1: operand capture; data registers only load on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= logic_op;
      end
    end
  end

  // Stage 2: result and flags; held while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      parity     <= 1'b0;
      illegal_op <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result     <= calc_result;
        zero       <= (calc_result == '0);
        parity     <= ^calc_result;
        illegal_op <= calc_illegal;
      end
    end
  end

`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
  // Consumed-beat counters: total wraps, illegal saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (s2_valid && out_ready) begin
      op_count <= op_count + 16'd1;
      if (illegal_op && (illegal_count != 8'hFF)) begin
        illegal_count <= illegal_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized self-checking bench for logic_unit_pipe. The reference model is a
// queue of in-flight beats: each beat becomes visible two edges after its
// accept, and the pipe holds at most two beats.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] logic_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       parity;
  logic       illegal_op;
`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
  logic [15:0] op_count;
  logic [7:0]  illegal_count;
`endif

  logic_unit_pipe #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .logic_op(logic_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity), .illegal_op(illegal_op)
`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
    , .op_count(op_count), .illegal_count(illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] r;
    logic       z;
    logic       p;
    logic       il;
  } beat_t;

  beat_t q[$];
  beat_t last;
  int    cyc;
  int    n_checks;
  int    n_errors;
  int    n_acc;
  int    n_cons;
  int    n_ill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic beat_t ref_beat(input logic [7:0] ra, input logic [7:0] rb, input int op);
    beat_t bt;
    int ones;
    bt.t  = 0;
    bt.il = (op >= 10);
    case (op)
      0: bt.r = ra & rb;
      1: bt.r = ra | rb;
      2: bt.r = ra ^ rb;
      3: bt.r = ~ra;
      4: bt.r = ~(ra & rb);
      5: bt.r = ~(ra | rb);
      6: bt.r = ~(ra ^ rb);
      7: bt.r = ra & ~rb;
      8: bt.r = ra;
      9: bt.r = rb;
      default: bt.r = 8'h00;
    endcase
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(bt.r[i]);
    bt.p = (ones % 2 == 1);
    bt.z = (bt.r == 8'h00);
    return bt;
  endfunction

  // One clock cycle: drive at negedge, check, then update model after posedge.
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [3:0] iop, input logic ordy);
    logic  vis;
    logic  rdy_exp;
    logic  acc;
    logic  cons;
    beat_t cur;
    beat_t nb;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; logic_op = iop; out_ready = ordy;
    #1;
    vis     = (q.size() > 0) && (cyc - q[0].t >= 2);
    rdy_exp = ordy || (q.size() < 2);
    check("out_valid", 32'(out_valid), 32'(vis));
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    cur = vis ? q[0] : last;
    check("result", 32'(result), 32'(cur.r));
    check("zero", 32'(zero), 32'(cur.z));
    check("parity", 32'(parity), 32'(cur.p));
    check("illegal_op", 32'(illegal_op), 32'(cur.il));
`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
    check("op_count", 32'(op_count), 32'(n_cons % 65536));
    check("illegal_count", 32'(illegal_count), 32'((n_ill > 255) ? 255 : n_ill));
`endif
    acc  = iv && rdy_exp;
    cons = vis && ordy;
    nb   = ref_beat(ia, ib, int'(iop));
    nb.t = cyc;
    @(posedge clk);
    cyc++;
    if (cons) begin
      last = q.pop_front();
      n_cons++;
      if (last.il) n_ill++;
    end
    if (acc) begin
      q.push_back(nb);
      n_acc++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    last   = '{t: 0, r: 8'h00, z: 1'b0, p: 1'b0, il: 1'b0};
    n_cons = 0;
    n_ill  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd0);
    check({tag, "_parity"}, 32'(parity), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
  endtask

  int budget;

  initial begin
    n_checks = 0; n_errors = 0; n_acc = 0; cyc = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; logic_op = 4'd1; out_ready = 1'b1;

    // Reset held with in_valid high for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Opcode sweep 0..9 plus illegal 12 at a=CA, b=5C.
    for (int op = 0; op < 10; op++) step(1'b1, 8'hCA, 8'h5C, 4'(op), 1'b1);
    step(1'b1, 8'hCA, 8'h5C, 4'd12, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);

    // Back-to-back streaming of 16 beats.
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);

    // Backpressure: exactly two beats fit while out_ready is low.
    n_acc = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0);
    check("bp_accepted", 32'(n_acc), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Fresh reset, then 1000 random beats with 50% valid/ready.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_acc = 0;
    budget = 0;
    while (n_acc < 1000 && budget < 20000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
      budget++;
    end
    check("rand_accept_budget", 32'(n_acc), 32'd1000);
    budget = 0;
    while (q.size() > 0 && budget < 200) begin
      step(1'b0, 8'h00, 8'h00, 4'd0, 1'($urandom_range(0, 1)));
      budget++;
    end
    check("rand_drain_budget", 32'(q.size()), 32'd0);
    check("rand_consumed", 32'(n_cons), 32'd1000);
    step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
    check("op_count_1000", 32'(op_count), 32'h3E8);
`endif

    // Mid-flight reset with two beats in the pipe.
    step(1'b1, 8'hF0, 8'h0F, 4'd1, 1'b0);
    step(1'b1, 8'h33, 8'h55, 4'd2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
